// File: rtl/ym_frame_player.sv
// YM5/YM6 music player: parses the file header held in music RAM, then streams
// the 14 AY register values of one frame on every accepted frame tick.
module ym_frame_player #(
  parameter int ADDR_W  = 17,
  parameter int STR_MAX = 1024
) (
  input  logic              clk_24,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic              stop,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [3:0]        ay_addr,
  output logic [7:0]        ay_data,
  output logic              ay_wr,
  output logic              playing,
  output logic              error,
  output logic [31:0]       frame
);

  // state | meaning
  // IDLE  | stopped, outputs at reset values
  // HDR   | reading and checking header bytes 0..33
  // STR   | skipping the three null-terminated strings
  // WAIT  | playing, waiting for the next frame tick
  // PLAY  | reading and writing the 14 registers of one frame
  // ERR   | unusable file, held until start or reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_STR,
    S_WAIT,
    S_PLAY,
    S_ERR
  } state_t;

  localparam int SCAN_W = $clog2(STR_MAX + 1);

  state_t            state;
  logic [5:0]        hdr_idx;
  logic              rq0;
  logic              rq1;
  logic [31:0]       nb_frames;
  logic [31:0]       loop_frame;
  logic [15:0]       nb_drums;
  logic [15:0]       extra;
  logic              interleaved;
  logic [ADDR_W-1:0] data_base;
  logic [ADDR_W-1:0] scan_addr;
  logic [SCAN_W-1:0] str_left;
  logic [1:0]        nulls;
  logic [3:0]        reg_idx;
  logic              phase;

  logic [15:0]       extra_nxt;
  logic [ADDR_W-1:0] str_addr;
  logic [ADDR_W-1:0] frame_addr;
  logic [ADDR_W-1:0] step_addr;
  logic [31:0]       frame_nxt;

  always_comb begin
    extra_nxt = {extra[7:0], mem_data};
    str_addr  = ADDR_W'(34) + ADDR_W'(extra_nxt);
    frame_nxt = frame + 32'd1;
    if (interleaved) begin
      frame_addr = data_base + frame[ADDR_W-1:0];
      step_addr  = mem_addr + nb_frames[ADDR_W-1:0];
    end else begin
      frame_addr = data_base + {frame[ADDR_W-5:0], 4'h0};
      step_addr  = mem_addr + ADDR_W'(1);
    end
  end

  function automatic logic magic_ok(input logic [5:0] idx, input logic [7:0] d);
    case (idx)
      6'd0:    magic_ok = (d == "Y");
      6'd1:    magic_ok = (d == "M");
      6'd2:    magic_ok = (d == "5") || (d == "6");
      6'd3:    magic_ok = (d == "!");
      6'd4:    magic_ok = (d == "L");
      6'd5:    magic_ok = (d == "e");
      6'd6:    magic_ok = (d == "O");
      6'd7:    magic_ok = (d == "n");
      6'd8:    magic_ok = (d == "A");
      6'd9:    magic_ok = (d == "r");
      6'd10:   magic_ok = (d == "D");
      6'd11:   magic_ok = (d == "!");
      default: magic_ok = 1'b1;
    endcase
  endfunction

  // rq0: mem_addr currently holds a wanted read; rq1: mem_data holds its data now
  always_ff @(posedge clk_24) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_addr    <= '0;
      ay_addr     <= '0;
      ay_data     <= '0;
      ay_wr       <= 1'b0;
      playing     <= 1'b0;
      error       <= 1'b0;
      frame       <= '0;
      hdr_idx     <= '0;
      rq0         <= 1'b0;
      rq1         <= 1'b0;
      nb_frames   <= '0;
      loop_frame  <= '0;
      nb_drums    <= '0;
      extra       <= '0;
      interleaved <= 1'b0;
      data_base   <= '0;
      scan_addr   <= '0;
      str_left    <= '0;
      nulls       <= '0;
      reg_idx     <= '0;
      phase       <= 1'b0;
    end else if (ce) begin
      ay_wr <= 1'b0;
      rq1   <= rq0;
      if (start) begin
        state      <= S_HDR;
        error      <= 1'b0;
        playing    <= 1'b0;
        frame      <= '0;
        mem_addr   <= '0;
        rq0        <= 1'b1;
        rq1        <= 1'b0;
        hdr_idx    <= '0;
        nb_frames  <= '0;
        loop_frame <= '0;
        nb_drums   <= '0;
        extra      <= '0;
      end else if (stop && state != S_ERR) begin
        state    <= S_IDLE;
        mem_addr <= '0;
        ay_addr  <= '0;
        ay_data  <= '0;
        playing  <= 1'b0;
        error    <= 1'b0;
        frame    <= '0;
        rq0      <= 1'b0;
        rq1      <= 1'b0;
      end else begin
        case (state)
          S_HDR: begin
            mem_addr <= mem_addr + ADDR_W'(1);
            rq0      <= 1'b1;
            if (rq1) begin
              hdr_idx <= hdr_idx + 6'd1;
              case (hdr_idx)
                6'd12, 6'd13, 6'd14, 6'd15: nb_frames  <= {nb_frames[23:0], mem_data};
                6'd19:                      interleaved <= mem_data[0];
                6'd20, 6'd21:               nb_drums   <= {nb_drums[7:0], mem_data};
                6'd28, 6'd29, 6'd30, 6'd31: loop_frame <= {loop_frame[23:0], mem_data};
                6'd32, 6'd33:               extra      <= extra_nxt;
                default: ;
              endcase
              if (!magic_ok(hdr_idx, mem_data)) begin
                state <= S_ERR;
                error <= 1'b1;
                rq0   <= 1'b0;
              end else if (hdr_idx == 6'd33) begin
                if (nb_frames == 32'd0 || nb_drums != 16'd0) begin
                  state <= S_ERR;
                  error <= 1'b1;
                  rq0   <= 1'b0;
                end else begin
                  if (loop_frame >= nb_frames) loop_frame <= '0;
                  state     <= S_STR;
                  mem_addr  <= str_addr;
                  scan_addr <= str_addr;
                  rq0       <= 1'b1;
                  rq1       <= 1'b0;
                  str_left  <= SCAN_W'(STR_MAX);
                  nulls     <= '0;
                end
              end
            end
          end

          S_STR: begin
            mem_addr <= mem_addr + ADDR_W'(1);
            rq0      <= 1'b1;
            if (rq1) begin
              scan_addr <= scan_addr + ADDR_W'(1);
              if (str_left == '0) begin
                state <= S_ERR;
                error <= 1'b1;
                rq0   <= 1'b0;
              end else begin
                str_left <= str_left - SCAN_W'(1);
                if (mem_data == 8'h00) begin
                  if (nulls == 2'd2) begin
                    data_base <= scan_addr + ADDR_W'(1);
                    state     <= S_WAIT;
                    playing   <= 1'b1;
                    rq0       <= 1'b0;
                  end else begin
                    nulls <= nulls + 2'd1;
                  end
                end
              end
            end
          end

          S_WAIT: begin
            rq0 <= 1'b0;
            if (frame_tick) begin
              state    <= S_PLAY;
              reg_idx  <= '0;
              phase    <= 1'b0;
              mem_addr <= frame_addr;
            end
          end

          // phase 0: RAM is latching mem_addr; phase 1: mem_data is the register value
          S_PLAY: begin
            if (!phase) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (!(reg_idx == 4'd13 && mem_data == 8'hFF)) begin
                ay_wr   <= 1'b1;
                ay_addr <= reg_idx;
                ay_data <= mem_data;
              end
              if (reg_idx == 4'd13) begin
                frame <= (frame_nxt == nb_frames) ? loop_frame : frame_nxt;
                state <= S_WAIT;
              end else begin
                reg_idx  <= reg_idx + 4'd1;
                mem_addr <= step_addr;
              end
            end
          end

          default: begin
            rq0 <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ym_frame_player.sv
// Scoreboard bench for ym_frame_player: builds YM files in a RAM model, plays
// ticks and compares every AY write against the expected register stream.
module tb_ym_frame_player;
  localparam int ADDR_W = 17;

  logic              clk_24 = 1'b0;
  logic              reset;
  logic              ce;
  logic              start;
  logic              stop;
  logic              frame_tick;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data = 8'h00;
  logic [3:0]        ay_addr;
  logic [7:0]        ay_data;
  logic              ay_wr;
  logic              playing;
  logic              error;
  logic [31:0]       frame;

  logic [7:0]  ram [0:(1<<ADDR_W)-1];
  logic [11:0] sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_extra  = 0;

  ym_frame_player #(.ADDR_W(ADDR_W), .STR_MAX(1024)) dut (
    .clk_24(clk_24), .reset(reset), .ce(ce), .start(start), .stop(stop),
    .frame_tick(frame_tick), .mem_addr(mem_addr), .mem_data(mem_data),
    .ay_addr(ay_addr), .ay_data(ay_data), .ay_wr(ay_wr),
    .playing(playing), .error(error), .frame(frame)
  );

  initial forever #5 clk_24 = ~clk_24;

  // ce at half clock rate, changing 2 ns after the rising edge
  initial begin
    ce = 1'b0;
    forever begin
      @(posedge clk_24);
      #2 ce = ~ce;
    end
  end

  always @(posedge clk_24) if (ce) mem_data <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ay_wr spans one ce period; count it on the half where ce is high
  always @(negedge clk_24) begin
    if (ay_wr && ce) begin
      if (sb.size() == 0) n_extra++;
      else check("ay_write", 32'({ay_addr, ay_data}), 32'(sb.pop_front()));
    end
  end

  task automatic pulse(input int which);
    @(negedge clk_24);
    while (!ce) @(negedge clk_24);
    case (which)
      0:       start = 1'b1;
      1:       stop = 1'b1;
      default: frame_tick = 1'b1;
    endcase
    @(negedge clk_24);
    start = 1'b0;
    stop = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic put_be(input int a, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) ram[a+i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic write_header(input logic [7:0] m, input logic [31:0] nbf, input logic attr,
                              input logic [15:0] drums, input logic [31:0] loop_f,
                              input logic [15:0] ext);
    string tag = "LeOnArD!";
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[0] = "Y";
    ram[1] = "M";
    ram[2] = m;
    ram[3] = "!";
    for (int i = 0; i < 8; i++) ram[4+i] = tag[i];
    put_be(12, nbf, 4);
    ram[19] = {7'd0, attr};
    put_be(20, 32'(drums), 2);
    put_be(28, loop_f, 4);
    put_be(32, 32'(ext), 2);
  endtask

  // register r of frame f holds f*16+r
  task automatic write_frames(input int base, input int nbf, input bit inter);
    for (int f = 0; f < nbf; f++)
      for (int r = 0; r < 14; r++)
        ram[inter ? base + r*nbf + f : base + f*16 + r] = 8'(f*16 + r);
  endtask

  task automatic push_frame(input int f, input bit skip13, input int nregs);
    for (int r = 0; r < nregs; r++)
      if (!(skip13 && r == 13)) sb.push_back({4'(r), 8'(f*16 + r)});
  endtask

  task automatic play_tick(input int f, input bit skip13, input int exp_frame);
    push_frame(f, skip13, 14);
    pulse(2);
    repeat (70) @(negedge clk_24);
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("frame", frame, 32'(exp_frame));
  endtask

  task automatic start_and_settle(input int limit);
    pulse(0);
    check("start_frame", frame, 32'd0);
    check("start_error", 32'(error), 32'd0);
    for (int i = 0; i < limit; i++) begin
      if (playing || error) break;
      @(negedge clk_24);
    end
  endtask

  task automatic expect_status(input string tag, input logic exp_play, input logic exp_err);
    check({tag, "_playing"}, 32'(playing), 32'(exp_play));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
  endtask

  task automatic file_simple(input logic [7:0] m);
    write_header(m, 32'd2, 1'b1, 16'd0, 32'd0, 16'd0);
    write_frames(37, 2, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b1;
    stop = 1'b1;
    frame_tick = 1'b1;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    repeat (6) @(negedge clk_24);
    start = 1'b0;
    stop = 1'b0;
    frame_tick = 1'b0;
    reset = 1'b0;
    check("rst_outs", {mem_addr, ay_addr, ay_data, ay_wr, playing, error}, 32'd0);
    check("rst_frame", frame, 32'd0);
    pulse(2);
    repeat (40) @(negedge clk_24);
    expect_status("idle", 1'b0, 1'b0);
    check("idle_extra", 32'(n_extra), 32'd0);

    // interleaved YM5, two frames, empty strings
    file_simple("5");
    start_and_settle(400);
    expect_status("t1", 1'b1, 1'b0);
    play_tick(0, 1'b0, 1);
    play_tick(1, 1'b0, 0);
    play_tick(0, 1'b0, 1);

    // YM6 non-interleaved, loop to 2, frame 2 has reg13 = 0xFF, extra=2, short strings
    write_header("6", 32'd4, 1'b0, 16'd0, 32'd2, 16'd2);
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 3; k++) ram[36 + s*4 + k] = "a";
      ram[36 + s*4 + 3] = 8'h00;
    end
    write_frames(48, 4, 1'b0);
    ram[48 + 2*16 + 13] = 8'hFF;
    start_and_settle(400);
    expect_status("t2", 1'b1, 1'b0);
    play_tick(0, 1'b0, 1);
    push_frame(1, 1'b0, 14);
    pulse(2);
    repeat (10) @(negedge clk_24);
    pulse(2);
    repeat (70) @(negedge clk_24);
    check("drop_drain", 32'(sb.size()), 32'd0);
    check("drop_frame", frame, 32'd2);
    repeat (70) @(negedge clk_24);
    check("drop_extra", 32'(n_extra), 32'd0);
    check("drop_frame_after", frame, 32'd2);
    play_tick(2, 1'b1, 3);
    play_tick(3, 1'b0, 2);
    play_tick(2, 1'b1, 3);
    check("t2_extra", 32'(n_extra), 32'd0);

    // bad magic, then recovery with a valid file
    file_simple("3");
    pulse(0);
    repeat (10) @(negedge clk_24);
    expect_status("magic", 1'b0, 1'b1);
    pulse(2);
    repeat (70) @(negedge clk_24);
    pulse(1);
    repeat (4) @(negedge clk_24);
    check("err_stop_ignored", 32'(error), 32'd1);
    check("magic_extra", 32'(n_extra), 32'd0);
    file_simple("5");
    start_and_settle(400);
    expect_status("recover", 1'b1, 1'b0);
    play_tick(0, 1'b0, 1);

    // nonzero drum count
    write_header("6", 32'd4, 1'b1, 16'd1, 32'd0, 16'd0);
    write_frames(37, 4, 1'b1);
    start_and_settle(400);
    expect_status("drums", 1'b0, 1'b1);

    // loop_frame beyond nb_frames wraps to 0
    write_header("5", 32'd4, 1'b1, 16'd0, 32'd9, 16'd0);
    write_frames(37, 4, 1'b1);
    start_and_settle(400);
    expect_status("loop", 1'b1, 1'b0);
    play_tick(0, 1'b0, 1);
    play_tick(1, 1'b0, 2);
    play_tick(2, 1'b0, 3);
    play_tick(3, 1'b0, 0);
    play_tick(0, 1'b0, 1);

    // third null exactly at the 1024th scanned byte
    write_header("5", 32'd1, 1'b1, 16'd0, 32'd0, 16'd0);
    for (int a = 36; a <= 1056; a++) ram[a] = "a";
    write_frames(1058, 1, 1'b1);
    start_and_settle(6000);
    expect_status("str1024", 1'b1, 1'b0);
    play_tick(0, 1'b0, 0);

    // third null at the 1025th scanned byte
    write_header("5", 32'd1, 1'b1, 16'd0, 32'd0, 16'd0);
    for (int a = 36; a <= 1057; a++) ram[a] = "a";
    write_frames(1059, 1, 1'b1);
    start_and_settle(6000);
    expect_status("str1025", 1'b0, 1'b1);
    check("str_extra", 32'(n_extra), 32'd0);

    // stop while reg 5 of a frame is pending
    file_simple("5");
    start_and_settle(400);
    expect_status("t8", 1'b1, 1'b0);
    push_frame(0, 1'b0, 5);
    pulse(2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_24);
      if (sb.size() == 0) break;
    end
    check("stop_pre_drain", 32'(sb.size()), 32'd0);
    pulse(1);
    check("stop_outs", {mem_addr, ay_addr, ay_data, ay_wr, playing, error}, 32'd0);
    check("stop_frame", frame, 32'd0);
    repeat (60) @(negedge clk_24);
    pulse(2);
    repeat (70) @(negedge clk_24);
    check("stop_extra", 32'(n_extra), 32'd0);
    check("stop_playing", 32'(playing), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ym_frame_player.md
Name: ym_frame_player

Overview:
- Plays YM5/YM6 music loaded into the music RAM through the F4 download slot (ioctl index 4).
- On a start pulse it parses the file header in RAM, then on each frame tick streams 14 AY register writes to the sound chip.
- Sits inside the system block. Upstream is the download-written music RAM, read through a synchronous read port. Downstream is the AY/YM sound generator register interface.

Parameters:
- ADDR_W, 17, music RAM byte-address width (matches dn_addr width).
- STR_MAX, 1024, maximum total bytes scanned while skipping the three header strings before flagging an error.

Ports:
- clk_24  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ce  input  1  clock enable; all state advances only when ce=1 (driven from ce_2)
- start  input  1  one-clk pulse: begin header parse (issued on falling edge of a download with index 4)
- stop  input  1  one-clk pulse: return to IDLE
- frame_tick  input  1  one-clk pulse at player rate (50 Hz)
- mem_addr  output  ADDR_W  music RAM read address
- mem_data  input  8  RAM data; valid on the ce cycle after mem_addr is presented
- ay_addr  output  4  AY register number
- ay_data  output  8  AY register value
- ay_wr  output  1  write strobe, one ce-qualified cycle per register
- playing  output  1  high in WAIT/PLAY
- error  output  1  sticky until next start/reset
- frame  output  32  current frame index

Behaviour:
Reset:
- All outputs are 0; state is IDLE.
- start or stop pulses arriving while reset is asserted are ignored.

States: IDLE, HDR, STR, WAIT, PLAY, ERR.
- start from any state clears error and frame, then enters HDR.
- stop from any state except ERR enters IDLE.
- start takes priority over stop in the same cycle.

HDR: reads bytes 0..33, one byte per ce, with pipelined addressing (1-ce read latency).
- Bytes 0..3 must be "YM5!" or "YM6!", and bytes 4..11 must be "LeOnArD!". Otherwise enter ERR.
- Captures, big-endian:
  - nb_frames from bytes 12..15
  - attr bit0 (interleaved) from byte 19
  - nb_drums from bytes 20..21
  - loop_frame from bytes 28..31
  - extra from bytes 32..33
- nb_frames==0 or nb_drums!=0 enters ERR.
- If loop_frame>=nb_frames, loop_frame is forced to 0.

STR:
- Starts at address 34+extra and scans until three 0x00 bytes have been seen.
- data_base = address after the third null.
- Scanning more than STR_MAX bytes enters ERR. Otherwise enter WAIT.

WAIT:
- frame_tick enters PLAY with reg=0.
- A frame_tick is accepted only in WAIT. Ticks arriving during PLAY are dropped and not queued.

PLAY: for reg 0..13, issue one RAM read, then one write.
- Address, interleaved: data_base + reg*nb_frames + frame. This is computed incrementally by adding nb_frames per reg; no multiplier is used.
- Address, non-interleaved: data_base + frame*16 + reg.
- All address sums are truncated to ADDR_W, wrapping modulo 2^ADDR_W.
- ay_wr pulses for one ce cycle, with ay_addr=reg and ay_data=mem_data.
- reg 13 (envelope shape) is suppressed when the value is 0xFF: no ay_wr, and reg still advances.
- After reg 13:
  - frame increments.
  - If frame==nb_frames, frame is set to loop_frame.
  - State returns to WAIT.
- Worst case is 28 ce cycles per frame, well below the tick period.

ERR:
- error=1, playing=0, no ay_wr.
- Only start or reset exits ERR.

stop mid-PLAY:
- Abandons the frame immediately; the remaining registers are not written.
- Outputs return to their reset values.

Test Plan:
- Interleaved YM5, nb_frames=2, no strings beyond the nulls, regs = frame*16+reg; start, then tick ×3 -> writes reg0..13 with values 0x00..0x0D, then 0x10..0x1D, then loops to frame 0 (0x00..0x0D); frame reads 1, 0, 1.
- YM6, attr=0 (non-interleaved), nb_frames=4, loop_frame=2 -> the fifth tick plays frame 2; reg 13 stored as 0xFF produces exactly 13 ay_wr pulses for that frame.
- Bad magic "YM3!" -> error=1 within 5 ce cycles of start, with no ay_wr; a second start with a valid file clears error.
- nb_drums=1 -> ERR; loop_frame=9 with nb_frames=4 -> wraps to frame 0 after frame 3.
- Unterminated strings (no null within 1024 bytes) -> ERR at the 1025th scanned byte.
- stop asserted at reg 5 of PLAY -> no further ay_wr, outputs reset; a frame_tick during PLAY is not replayed afterwards.
